mips_multicycle_controller: RTL
===============================

# mips_multicycle_controller

Multi-cycle sequencer for the 19-bit MIPS-style core. It replaces single-cycle control with a FETCH/DECODE/EXEC/MEM/WB state machine so that instructions and data share one memory port with a ready handshake. It drives the existing datapath controls (ALU/shift codes, register write, PC source, call stack) plus IR/PC write enables. It traps on call-stack overflow and underflow.

## Interface
Parameters: none (ISA widths fixed).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instruction  in  19  IR contents; valid from DECODE onward
- zero  in  1  registered ALU zero flag
- carry  in  1  registered ALU carry flag
- mem_ready  in  1  memory completes current request this cycle
- stack_full  in  1  return-address stack full
- stack_empty  in  1  return-address stack empty
- mem_req  out  1  memory access request
- mem_read_write  out  1  0 = read, 1 = write
- inst_or_data  out  1  address mux: 0 = PC, 1 = ALU result
- ir_write  out  1  latch memory data into IR
- pc_write  out  1  load PC from pc_src mux
- pc_src  out  2  00 = PC+1, 01 = branch/jump target, 10 = stack top
- reg2_read_source, mem_or_alu, is_shift, alu_src, reg_read_write  out  1 each  datapath selects/enables
- flags_write  out  1  update zero/carry registers
- stack_push, stack_pop  out  1 each  return-stack operations
- scode  out  2  shifter code
- acode  out  3  ALU code
- fault  out  1  sticky stack trap
- state  out  3  current state (debug)

## Operation
- States and encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5.
- Outputs are combinational from state, instruction, flags and mem_ready. All outputs are 0 except where listed below.
- Instruction classes:
  - [18:17]=00: ALU reg; acode=[16:14].
  - 01: ALU immediate; acode=[16:14], alu_src=1.
  - [18:16]=110: shift; scode=[15:14], is_shift=1.
  - 100 with [15:14]=00: load. With [15:14]=01: store.
  - 101: conditional branch.
  - [18:15]=1110: jump; [14]=1 makes it jsb.
  - [18:13]=111100: ret.
  - Anything else: NOP.
- FETCH: mem_req=1, inst_or_data=0, mem_read_write=0. On mem_ready: ir_write=1, pc_write=1, pc_src=00, next DECODE. Otherwise stay.
- DECODE: no outputs; one cycle; next EXEC.
- EXEC, ALU/shift: class codes driven, flags_write=1; next WB.
- EXEC, load/store: alu_src=1, reg2_read_source=1; next MEM.
- EXEC, branch: condition per [15:14]: 00 zero=1, 01 zero=0, 10 carry=1, 11 carry=0. If true, pc_write=1 and pc_src=01. Next FETCH.
- EXEC, jump: pc_write=1, pc_src=01. jsb also asserts stack_push=1. Next FETCH.
- EXEC, ret: pc_write=1, pc_src=10, stack_pop=1; next FETCH.
- EXEC, NOP: next FETCH.
- EXEC, jsb with stack_full=1 or ret with stack_empty=1: no push/pop, no pc_write; next FAULT.
- MEM: mem_req=1, inst_or_data=1, alu_src=1, reg2_read_source=1, mem_read_write=1 for store. On mem_ready: store goes to FETCH, load goes to WB. Otherwise stay with outputs held.
- WB: reg_read_write=1.
  - ALU/shift: mem_or_alu=1, acode/scode/alu_src/is_shift held as in EXEC.
  - Load: mem_or_alu=0, alu_src=1, reg2_read_source=1.
  - Next FETCH.
- FAULT: fault=1, all other outputs 0. Leaves FAULT only via rst.

## Timing
- Reset: while rst=1, state=FETCH and every output forced to 0. The first fetch request goes out the cycle after rst deasserts. Reset mid-instruction abandons it with no further writes.
- mem_ready is sampled on the rising edge while mem_req=1. mem_ready while mem_req=0 is ignored.
- Latency with zero wait states: ALU/shift 4 cycles, load 5, store 4, branch/jump/ret/NOP 3. Each memory wait cycle adds 1.
- Flags are sampled combinationally in EXEC only. flags_write in EXEC updates them for the next instruction.
- stack_push, stack_pop and pc_write are single-cycle pulses.

## Test plan
- ALU reg 0b00_011_xxxxxxxxxxxxxx, mem_ready always 1 -> states 0,1,2,4,0; acode=011 in EXEC/WB; reg_read_write=1 in WB only; ir_write=1 in FETCH only.
- Load with mem_ready low 2 cycles in MEM -> MEM lasts 3 cycles with mem_req=1, inst_or_data=1; then WB with mem_or_alu=0, reg_read_write=1; total 7 cycles.
- Branch [18:14]=10110, carry=1 -> pc_write=1, pc_src=01 in EXEC. Same with carry=0 -> pc_write=0. Both return to FETCH after 3 cycles.
- jsb (1110_1) with stack_full=0 -> stack_push=1, pc_src=01 for one cycle. Then ret (111100) with stack_empty=0 -> stack_pop=1, pc_src=10.
- ret with stack_empty=1 -> no pop, no pc_write; state=5, fault=1 held through further clocks. Pulse rst -> fault=0, state=0.
- Assert rst during MEM of a store -> outputs 0 immediately (asynchronous). After release, restart at FETCH; no write issued.

Source files
------------

// File: rtl/mips_multicycle_controller_if.sv
// Control bundle between the multi-cycle sequencer and the 19-bit datapath/memory port.
// The master side is the controller; the slave side is the datapath (or a bench standing in for it).
interface mips_multicycle_controller_if;
    logic [18:0] instruction;
    logic        zero;
    logic        carry;
    logic        mem_ready;
    logic        stack_full;
    logic        stack_empty;

    // mem_req/mem_ready form a request/complete pair: the access finishes on the rising edge
    // where both are 1; mem_ready is meaningless while mem_req is 0.
    logic        mem_req;
    logic        mem_read_write;
    logic        inst_or_data;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        reg2_read_source;
    logic        mem_or_alu;
    logic        is_shift;
    logic        alu_src;
    logic        reg_read_write;
    logic        flags_write;
    logic        stack_push;
    logic        stack_pop;
    logic [1:0]  scode;
    logic [2:0]  acode;
    logic        fault;
    logic [2:0]  state;

    modport master (
        input  instruction, zero, carry, mem_ready, stack_full, stack_empty,
        output mem_req, mem_read_write, inst_or_data, ir_write, pc_write, pc_src,
               reg2_read_source, mem_or_alu, is_shift, alu_src, reg_read_write,
               flags_write, stack_push, stack_pop, scode, acode, fault, state
    );

    modport slave (
        output instruction, zero, carry, mem_ready, stack_full, stack_empty,
        input  mem_req, mem_read_write, inst_or_data, ir_write, pc_write, pc_src,
               reg2_read_source, mem_or_alu, is_shift, alu_src, reg_read_write,
               flags_write, stack_push, stack_pop, scode, acode, fault, state
    );
endinterface

// File: rtl/mips_multicycle_controller.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer sharing one memory port for instructions and data.
// Outputs are combinational from state, IR and flags; a stack over/underflow locks into FAULT.
module mips_multicycle_controller (
    input  logic                          clk,
    input  logic                          rst,
    mips_multicycle_controller_if.master  ctrl
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_ALU, C_ALUI, C_SHIFT, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_JSB, C_RET, C_NOP
    } iclass_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_read_write;
        logic       inst_or_data;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg2_read_source;
        logic       mem_or_alu;
        logic       is_shift;
        logic       alu_src;
        logic       reg_read_write;
        logic       flags_write;
        logic       stack_push;
        logic       stack_pop;
        logic [1:0] scode;
        logic [2:0] acode;
        logic       fault;
    } ctl_t;

    state_t  state_q, state_d;
    iclass_t iclass;
    logic    branch_taken;
    ctl_t    o;

    always_comb begin
        iclass = C_NOP;
        if (ctrl.instruction[18:17] == 2'b00)                                      iclass = C_ALU;
        else if (ctrl.instruction[18:17] == 2'b01)                                 iclass = C_ALUI;
        else if (ctrl.instruction[18:16] == 3'b110)                                iclass = C_SHIFT;
        else if (ctrl.instruction[18:14] == 5'b10000)                              iclass = C_LOAD;
        else if (ctrl.instruction[18:14] == 5'b10001)                              iclass = C_STORE;
        else if (ctrl.instruction[18:16] == 3'b101)                                iclass = C_BRANCH;
        else if (ctrl.instruction[18:15] == 4'b1110)                               iclass = ctrl.instruction[14] ? C_JSB : C_JUMP;
        else if (ctrl.instruction[18:13] == 6'b111100)                             iclass = C_RET;
    end

    always_comb begin
        case (ctrl.instruction[15:14])
            2'b00:   branch_taken = ctrl.zero;
            2'b01:   branch_taken = !ctrl.zero;
            2'b10:   branch_taken = ctrl.carry;
            default: branch_taken = !ctrl.carry;
        endcase
    end

    // ALU/shift selects are identical in EXEC and WB so the result is still valid at write-back.
    function automatic ctl_t with_alu_fields(input ctl_t c, input iclass_t k, input logic [18:0] ins);
        ctl_t r;
        r = c;
        if (k == C_ALU || k == C_ALUI) r.acode = ins[16:14];
        if (k == C_ALUI)               r.alu_src = 1'b1;
        if (k == C_SHIFT) begin
            r.scode    = ins[15:14];
            r.is_shift = 1'b1;
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        o       = '0;
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                o.mem_req = 1'b1;
                if (ctrl.mem_ready) begin
                    o.ir_write = 1'b1;
                    o.pc_write = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                state_d = S_FETCH;
                case (iclass)
                    C_ALU, C_ALUI, C_SHIFT: begin
                        o             = with_alu_fields(o, iclass, ctrl.instruction);
                        o.flags_write = 1'b1;
                        state_d       = S_WB;
                    end
                    C_LOAD, C_STORE: begin
                        o.alu_src          = 1'b1;
                        o.reg2_read_source = 1'b1;
                        state_d            = S_MEM;
                    end
                    C_BRANCH: begin
                        o.pc_write = branch_taken;
                        o.pc_src   = branch_taken ? 2'b01 : 2'b00;
                    end
                    C_JUMP: begin
                        o.pc_write = 1'b1;
                        o.pc_src   = 2'b01;
                    end
                    C_JSB: begin
                        if (ctrl.stack_full) state_d = S_FAULT;
                        else begin
                            o.pc_write   = 1'b1;
                            o.pc_src     = 2'b01;
                            o.stack_push = 1'b1;
                        end
                    end
                    C_RET: begin
                        if (ctrl.stack_empty) state_d = S_FAULT;
                        else begin
                            o.pc_write  = 1'b1;
                            o.pc_src    = 2'b10;
                            o.stack_pop = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                o.mem_req          = 1'b1;
                o.inst_or_data     = 1'b1;
                o.alu_src          = 1'b1;
                o.reg2_read_source = 1'b1;
                o.mem_read_write   = (iclass == C_STORE);
                if (ctrl.mem_ready) state_d = (iclass == C_LOAD) ? S_WB : S_FETCH;
            end
            S_WB: begin
                o.reg_read_write = 1'b1;
                if (iclass == C_LOAD) begin
                    o.alu_src          = 1'b1;
                    o.reg2_read_source = 1'b1;
                end else begin
                    o            = with_alu_fields(o, iclass, ctrl.instruction);
                    o.mem_or_alu = 1'b1;
                end
                state_d = S_FETCH;
            end
            S_FAULT: o.fault = 1'b1;
            default: state_d = S_FETCH;
        endcase
        // Reset is asynchronous, so the outputs must drop in the same cycle it rises.
        if (rst) o = '0;
    end

    assign ctrl.mem_req          = o.mem_req;
    assign ctrl.mem_read_write   = o.mem_read_write;
    assign ctrl.inst_or_data     = o.inst_or_data;
    assign ctrl.ir_write         = o.ir_write;
    assign ctrl.pc_write         = o.pc_write;
    assign ctrl.pc_src           = o.pc_src;
    assign ctrl.reg2_read_source = o.reg2_read_source;
    assign ctrl.mem_or_alu       = o.mem_or_alu;
    assign ctrl.is_shift         = o.is_shift;
    assign ctrl.alu_src          = o.alu_src;
    assign ctrl.reg_read_write   = o.reg_read_write;
    assign ctrl.flags_write      = o.flags_write;
    assign ctrl.stack_push       = o.stack_push;
    assign ctrl.stack_pop        = o.stack_pop;
    assign ctrl.scode            = o.scode;
    assign ctrl.acode            = o.acode;
    assign ctrl.fault            = o.fault;
    assign ctrl.state            = state_q;
endmodule
